// File: rtl/clock_ui_pkg.sv
// Shared definitions for the clock user-interface blocks: classifier state
// encoding and tick counts for the 10 kHz counter clock.
package clock_ui_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } press_state_t;

  localparam int TICKS_20MS  = 200;
  localparam int TICKS_200MS = 2000;
  localparam int TICKS_1S    = 10000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; once all bits are set the count stays put.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/press_classifier.sv
// Turns one debounced button level into one-cycle short, long and auto-repeat
// pulses by timing how long the button stays down.
module press_classifier
  import clock_ui_pkg::*;
#(
  parameter int CNT_W        = 14,
  parameter int MIN_TICKS    = TICKS_20MS,
  parameter int LONG_TICKS   = TICKS_1S,
  parameter int REPEAT_TICKS = TICKS_200MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             enable,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             held,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  press_state_t     state;
  press_state_t     next_state;
  logic             btn_prev;
  logic             press;
  logic [CNT_W-1:0] rep_cnt;
  logic             hold_clr;
  logic             hold_inc;
  logic             rep_clr;
  logic             rep_inc;
  logic             short_next;
  logic             long_next;
  logic             repeat_next;

  // A press is a rising edge only; btn_prev resets high so a button held
  // through reset (or through a disable) must be released before it counts.
  assign press = btn_in && !btn_prev;

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (hold_clr),
    .inc   (hold_inc),
    .count (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_rep_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (rep_clr),
    .inc   (rep_inc),
    .count (rep_cnt)
  );

  // State register, edge-detect history and the registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      btn_prev     <= 1'b1;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= next_state;
      btn_prev     <= btn_in;
      short_pulse  <= short_next;
      long_pulse   <= long_next;
      repeat_pulse <= repeat_next;
      held         <= (next_state != IDLE);
    end
  end

  // Next-state decisions, counter controls and which pulse (if any) to fire.
  always_comb begin
    next_state  = state;
    hold_clr    = 1'b0;
    hold_inc    = 1'b0;
    rep_clr     = 1'b0;
    rep_inc     = 1'b0;
    short_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;

    if (!enable) begin
      next_state = IDLE;
      hold_clr   = 1'b1;
      rep_clr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          rep_clr = 1'b1;
          if (press) begin
            next_state = PRESS;
            hold_inc   = 1'b1;
          end else begin
            hold_clr = 1'b1;
          end
        end

        PRESS: begin
          if (btn_in) begin
            hold_inc = 1'b1;
            if (hold_cnt == LONG_LAST) begin
              long_next  = 1'b1;
              rep_clr    = 1'b1;
              next_state = LONG;
            end
          end else begin
            short_next = (hold_cnt >= MIN_CNT);
            next_state = IDLE;
            hold_clr   = 1'b1;
            rep_clr    = 1'b1;
          end
        end

        LONG: begin
          if (btn_in) begin
            hold_inc = 1'b1;
            if (rep_cnt == REPEAT_LAST) begin
              repeat_next = 1'b1;
              rep_clr     = 1'b1;
            end else begin
              rep_inc = 1'b1;
            end
          end else begin
            next_state = IDLE;
            hold_clr   = 1'b1;
            rep_clr    = 1'b1;
          end
        end

        default: begin
          next_state = IDLE;
          hold_clr   = 1'b1;
          rep_clr    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Converts one debounced push-button level into one-cycle event pulses: short press, long press and auto-repeat.
- Sits between a `debounce` instance and the `FSM`. Its outputs drive the FSM's `inc_short`/`inc_long` inputs and the counter's increment input.
- Runs on the 10 kHz counter clock.
- Replaces the current scheme of separate physical short/long buttons with one button timed in hardware.

Parameters:
- CNT_W, 14, width of the hold counter. Must satisfy LONG_TICKS <= 2^CNT_W-1.
- MIN_TICKS, 200, minimum held samples for a valid short press (20 ms glitch reject).
- LONG_TICKS, 10000, held samples that qualify as a long press (1 s). MIN_TICKS < LONG_TICKS.
- REPEAT_TICKS, 2000, auto-repeat period while still held after a long press (0.2 s). Must be >= 1.

Ports:
- clk  in  1  10 kHz clock (clk_10000Hz from clkdiv).
- rst  in  1  synchronous, active-high reset.
- btn_in  in  1  debounced button level, 1 = pressed.
- enable  in  1  0 = classifier idle, all pulses suppressed.
- short_pulse  out  1  one-cycle pulse on a valid short release.
- long_pulse  out  1  one-cycle pulse when the hold reaches LONG_TICKS.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_TICKS during a long hold.
- held  out  1  1 while in PRESS or LONG.
- hold_cnt  out  CNT_W  samples held in the current press; saturating.

Behaviour:
- One clock; reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - short_pulse, long_pulse, repeat_pulse, held = 0.
  - hold_cnt = 0, rep_cnt = 0.
  - btn_prev = 1, so a button held through reset is ignored until it is released.
- btn_prev registers btn_in every cycle regardless of state or enable.
- A press is detected only when btn_in=1 and btn_prev=0 (rising edge).
- All pulse outputs are registered, last exactly one cycle, and are mutually exclusive.
- IDLE:
  - On a press with enable=1: go to PRESS, hold_cnt<=1. This sampling edge is called edge 0.
  - Otherwise stay in IDLE with hold_cnt<=0.
- PRESS:
  - btn_in=1: hold_cnt<=hold_cnt+1.
  - If btn_in=1 and hold_cnt==LONG_TICKS-1 (edge LONG_TICKS-1): long_pulse<=1, rep_cnt<=0, go to LONG.
  - btn_in=0 at edge R (hold_cnt==R): if R>=MIN_TICKS then short_pulse<=1. Go to IDLE either way, hold_cnt<=0.
- LONG:
  - btn_in=1: hold_cnt increments and saturates at 2^CNT_W-1.
  - btn_in=1: rep_cnt increments. When rep_cnt==REPEAT_TICKS-1: repeat_pulse<=1, rep_cnt<=0.
  - The first repeat is at edge LONG_TICKS-1+REPEAT_TICKS; later repeats follow every REPEAT_TICKS edges.
  - btn_in=0: go to IDLE with no pulse. Releasing a long press never produces short_pulse.
- held = (state != IDLE), registered together with the state.
- enable=0 in any state:
  - Next state is IDLE, counters clear, no pulse is emitted that cycle.
  - A button still held when enable returns produces no press until it is released and pressed again (btn_prev rule).
- rst mid-press: every output drops to 0 on the reset edge; no pulse is emitted.
- Simultaneous conditions:
  - Release at the same edge where hold_cnt==LONG_TICKS-1 counts as a release: short_pulse, not long_pulse.
  - A press edge arriving during reset is ignored.
- Latency: every pulse is visible in the cycle after the deciding sampling edge.

Decomposition:
- Shared package clock_ui_pkg holds:
  - State encoding: IDLE=2'd0, PRESS=2'd1, LONG=2'd2.
  - Tick constants for the 10 kHz clock: TICKS_20MS=200, TICKS_200MS=2000, TICKS_1S=10000.
- One sub-module is natural: sat_counter (parameterised width, synchronous clear, increment, saturate). It is instantiated for hold_cnt and rep_cnt.
- The FSM and pulse registers stay in press_classifier.

Test Plan:
(All scenarios use MIN_TICKS=3, LONG_TICKS=20, REPEAT_TICKS=5, enable=1 unless stated.)
1. Held through reset: btn_in=1 during rst and for 30 cycles after it -> no pulses, held=0. Then release, then press for 8 cycles -> exactly one short_pulse, in the cycle after the release edge; hold_cnt reads 8 just before that edge.
2. Glitch: press for 2 cycles, then release -> no pulse, held high for 2 cycles, hold_cnt returns to 0.
3. Long with repeats: press for 32 cycles -> long_pulse registered at edge 19, repeat_pulse at edges 24 and 29, no short_pulse on release, held=0 after release.
4. Boundary: release sampled at edge 19 (19 samples held) -> short_pulse only, long_pulse stays 0. Press held through edge 19 -> long_pulse.
5. enable dropped at edge 10 of a press and restored at edge 15 while still held -> no pulses, held=0. After release and a fresh 5-cycle press -> one short_pulse.
6. rst asserted at edge 22 of a long hold -> all outputs 0 at the next cycle. With btn_in kept at 1, no pulse occurs until a new rising edge.
